// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, response buffer and IF/ID register.
// state | meaning
// ISSUE | drive imem_req for pcF this cycle
// WAIT  | request outstanding, waiting for imem_valid
// DROP  | outstanding request was redirected away; discard its response
// HOLD  | response captured in buffer while pipeline is stalled
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pc_srcE,
  input  logic [31:0] pc_targetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus4D,
  output logic        validD,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } fetchState_t;

  fetchState_t state;
  fetchState_t stateNext;

  logic [31:0] bufInstr;
  logic [31:0] bufNext;
  logic [31:0] pcPlus4;
  logic [31:0] pcNext;
  logic        stallAny;
  logic        deliver;
  logic [31:0] deliverInstr;

  logic [31:0] instrNext;
  logic [31:0] pcDNext;
  logic [31:0] pcPlus4DNext;
  logic        validNext;

  assign pcPlus4  = pcF + 32'd4;
  assign stallAny = stallF | stallD;

  always_comb begin
    stateNext    = state;
    bufNext      = bufInstr;
    deliver      = 1'b0;
    deliverInstr = imem_rdata;
    imem_req     = 1'b0;
    case (state)
      ISSUE: begin
        imem_req  = 1'b1;
        stateNext = pc_srcE ? ISSUE : WAIT;
      end
      WAIT: begin
        if (pc_srcE) begin
          stateNext = imem_valid ? ISSUE : DROP;
        end else if (imem_valid) begin
          if (stallAny) begin
            bufNext   = imem_rdata;
            stateNext = HOLD;
          end else begin
            deliver   = 1'b1;
            stateNext = ISSUE;
          end
        end
      end
      DROP: begin
        if (imem_valid) begin
          stateNext = ISSUE;
        end
      end
      HOLD: begin
        deliverInstr = bufInstr;
        if (pc_srcE) begin
          bufNext   = '0;
          stateNext = ISSUE;
        end else if (!stallAny) begin
          deliver   = 1'b1;
          stateNext = ISSUE;
        end
      end
      default: stateNext = ISSUE;
    endcase
  end

  // A redirect always wins; otherwise the PC only moves when an instruction is handed over.
  always_comb begin
    pcNext = pcF;
    if (pc_srcE) begin
      pcNext = pc_targetE;
    end else if (deliver) begin
      pcNext = pcPlus4;
    end
  end

  // Flush beats stall beats delivery; an idle cycle leaves a bubble behind.
  always_comb begin
    instrNext    = instrD;
    pcDNext      = pcD;
    pcPlus4DNext = pc_plus4D;
    validNext    = validD;
    if (flushD) begin
      instrNext = NOP_INSTR;
      validNext = 1'b0;
    end else if (!stallD) begin
      if (deliver) begin
        instrNext    = deliverInstr;
        pcDNext      = pcF;
        pcPlus4DNext = pcPlus4;
        validNext    = 1'b1;
      end else begin
        instrNext = NOP_INSTR;
        validNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISSUE;
      pcF       <= RESET_PC;
      bufInstr  <= '0;
      instrD    <= NOP_INSTR;
      pcD       <= '0;
      pc_plus4D <= '0;
      validD    <= 1'b0;
    end else begin
      state     <= stateNext;
      pcF       <= pcNext;
      bufInstr  <= bufNext;
      instrD    <= instrNext;
      pcD       <= pcDNext;
      pc_plus4D <= pcPlus4DNext;
      validD    <= validNext;
    end
  end

  assign imem_addr  = pcF;
  assign fetch_busy = ~deliver;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        pc_srcE;
  logic [31:0] pc_targetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;
  logic        validD;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pc_srcE(pc_srcE), .pc_targetE(pc_targetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pcF(pcF), .instrD(instrD),
    .pcD(pcD), .pc_plus4D(pc_plus4D), .validD(validD), .fetch_busy(fetch_busy)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    stallF = 0; stallD = 0; flushD = 0; pc_srcE = 0; pc_targetE = '0;
    imem_valid = 0; imem_rdata = '0;
  endtask

  task automatic doReset;
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    doReset();
    #1;
    checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pcF got %h want %h", pcF, 32'h0); end
    checks++; if (instrD !== NOP) begin errors++; $display("FAIL reset_instrD got %h want %h", instrD, NOP); end
    checks++; if (pcD !== 32'h0) begin errors++; $display("FAIL reset_pcD got %h want %h", pcD, 32'h0); end
    checks++; if (pc_plus4D !== 32'h0) begin errors++; $display("FAIL reset_pc_plus4D got %h want %h", pc_plus4D, 32'h0); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL reset_validD got %b want 0", validD); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h want %h", imem_addr, 32'h0); end
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", fetch_busy); end
  endtask

  task automatic test_basic;
    doReset();
    tick();
    imem_valid = 1; imem_rdata = 32'h00A0_0093;
    #1;
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", fetch_busy); end
    tick();
    imem_valid = 0; imem_rdata = '0;
    #1;
    checks++; if (validD !== 1'b1) begin errors++; $display("FAIL basic_validD got %b want 1", validD); end
    checks++; if (instrD !== 32'h00A0_0093) begin errors++; $display("FAIL basic_instrD got %h want %h", instrD, 32'h00A0_0093); end
    checks++; if (pcD !== 32'h0) begin errors++; $display("FAIL basic_pcD got %h want %h", pcD, 32'h0); end
    checks++; if (pc_plus4D !== 32'h4) begin errors++; $display("FAIL basic_pc_plus4D got %h want %h", pc_plus4D, 32'h4); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL basic_addr got %h want %h", imem_addr, 32'h4); end
  endtask

  task automatic test_hold;
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = 32'h1111_2222;
    w1 = 32'h3333_4444;
    doReset();
    tick();
    imem_valid = 1; imem_rdata = w0;
    tick();
    imem_valid = 0; stallD = 1;
    tick();
    imem_valid = 1; imem_rdata = w1; stallF = 1; stallD = 1;
    #1;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", fetch_busy); end
    tick();
    imem_valid = 0; imem_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (validD !== 1'b1 || instrD !== w0 || pcD !== 32'h0) begin
        errors++; $display("FAIL hold_ifid[%0d] got %b/%h/%h want 1/%h/%h", k, validD, instrD, pcD, w0, 32'h0);
      end
      checks++; if (pcF !== 32'h4) begin errors++; $display("FAIL hold_pcF[%0d] got %h want %h", k, pcF, 32'h4); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %b want 0", k, imem_req); end
      if (k < 2) tick();
    end
    stallF = 0; stallD = 0;
    #1;
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL hold_release_busy got %b want 0", fetch_busy); end
    tick();
    #1;
    checks++; if (instrD !== w1) begin errors++; $display("FAIL hold_instrD got %h want %h", instrD, w1); end
    checks++; if (pcD !== 32'h4 || pc_plus4D !== 32'h8) begin errors++; $display("FAIL hold_pcD got %h/%h want %h/%h", pcD, pc_plus4D, 32'h4, 32'h8); end
    checks++; if (pcF !== 32'h8) begin errors++; $display("FAIL hold_pcF_adv got %h want %h", pcF, 32'h8); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL hold_next_req got %b/%h want 1/%h", imem_req, imem_addr, 32'h8); end
  endtask

  task automatic test_redirect;
    doReset();
    tick();
    pc_srcE = 1; pc_targetE = 32'h100;
    tick();
    pc_srcE = 0; pc_targetE = '0;
    #1;
    checks++; if (pcF !== 32'h100) begin errors++; $display("FAIL redir_pcF got %h want %h", pcF, 32'h100); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_drop_req got %b want 0", imem_req); end
    tick();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_drop_req2 got %b want 0", imem_req); end
    imem_valid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL redir_late_busy got %b want 1", fetch_busy); end
    tick();
    imem_valid = 0; imem_rdata = '0;
    #1;
    checks++; if (validD !== 1'b0 || instrD !== NOP) begin errors++; $display("FAIL redir_dropped got %b/%h want 0/%h", validD, instrD, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %b/%h want 1/%h", imem_req, imem_addr, 32'h100); end
    tick();
    imem_valid = 1; imem_rdata = 32'h5555_AAAA;
    tick();
    imem_valid = 0;
    #1;
    checks++; if (instrD !== 32'h5555_AAAA || pcD !== 32'h100 || pc_plus4D !== 32'h104) begin
      errors++; $display("FAIL redir_deliver got %h/%h/%h want %h/%h/%h", instrD, pcD, pc_plus4D, 32'h5555_AAAA, 32'h100, 32'h104);
    end
  endtask

  task automatic test_flush_stall;
    doReset();
    tick();
    imem_valid = 1; imem_rdata = 32'h0123_4567;
    tick();
    imem_valid = 0; flushD = 1; stallD = 1;
    tick();
    flushD = 0; stallD = 0;
    #1;
    checks++; if (instrD !== NOP || validD !== 1'b0) begin errors++; $display("FAIL flush_bubble got %h/%b want %h/0", instrD, validD, NOP); end
    checks++; if (pcD !== 32'h0 || pc_plus4D !== 32'h4) begin errors++; $display("FAIL flush_pcD got %h/%h want %h/%h", pcD, pc_plus4D, 32'h0, 32'h4); end
  endtask

  task automatic test_wrap;
    doReset();
    tick();
    pc_srcE = 1; pc_targetE = 32'hFFFF_FFFC; imem_valid = 1; imem_rdata = 32'hBAAD_BAAD;
    #1;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL wrap_discard_busy got %b want 1", fetch_busy); end
    tick();
    pc_srcE = 0; pc_targetE = '0; imem_valid = 0;
    #1;
    checks++; if (pcF !== 32'hFFFF_FFFC || validD !== 1'b0) begin errors++; $display("FAIL wrap_redirect got %h/%b want %h/0", pcF, validD, 32'hFFFF_FFFC); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %b/%h want 1/%h", imem_req, imem_addr, 32'hFFFF_FFFC); end
    tick();
    imem_valid = 1; imem_rdata = 32'h0000_0513;
    tick();
    imem_valid = 0;
    #1;
    checks++; if (pcD !== 32'hFFFF_FFFC || pc_plus4D !== 32'h0) begin errors++; $display("FAIL wrap_pcD got %h/%h want %h/%h", pcD, pc_plus4D, 32'hFFFF_FFFC, 32'h0); end
    checks++; if (instrD !== 32'h0000_0513 || validD !== 1'b1) begin errors++; $display("FAIL wrap_instr got %h/%b want %h/1", instrD, validD, 32'h0000_0513); end
    checks++; if (pcF !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h/%h want 0/0", pcF, imem_addr); end
  endtask

  task automatic test_reset_midwait;
    doReset();
    tick();
    imem_valid = 1; imem_rdata = 32'hAAAA_0001;
    tick();
    imem_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (pcF !== 32'h0 || validD !== 1'b0) begin errors++; $display("FAIL midrst_state got %h/%b want 0/0", pcF, validD); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_req got %b/%h want 1/0", imem_req, imem_addr); end
    checks++; if (instrD !== NOP) begin errors++; $display("FAIL midrst_instr got %h want %h", instrD, NOP); end
    tick();
    imem_valid = 1; imem_rdata = 32'hAAAA_0002;
    tick();
    imem_valid = 0;
    #1;
    checks++; if (validD !== 1'b1 || pcD !== 32'h0 || instrD !== 32'hAAAA_0002) begin
      errors++; $display("FAIL midrst_deliver got %b/%h/%h want 1/0/%h", validD, pcD, instrD, 32'hAAAA_0002);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    doReset();
    for (int k = 0; k < 8; k++) begin
      a = 32'(k) * 32'd4;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL b2b_req[%0d] got %b/%h want 1/%h", k, imem_req, imem_addr, a); end
      tick();
      imem_valid = 1; imem_rdata = memWord(a);
      tick();
      imem_valid = 0;
      #1;
      checks++; if (validD !== 1'b1 || pcD !== a || instrD !== memWord(a)) begin
        errors++; $display("FAIL b2b_deliver[%0d] got %b/%h/%h want 1/%h/%h", k, validD, pcD, instrD, a, memWord(a));
      end
    end
  endtask

  // Transaction-level reference: one outstanding fetch (possibly marked dead), or one parked word.
  task automatic test_random;
    logic [31:0] mPc, mReqAddr, mBufWord, mBufAddr, mInstr, mPcD, mPc4D, mWord, mWordAddr, memAddr;
    bit mOut, mDead, mBuf, mValidD, mReq, mDeliver, memPend;
    int memLeft;
    doReset();
    mPc = 0; mReqAddr = 0; mBufWord = 0; mBufAddr = 0;
    mInstr = NOP; mPcD = 0; mPc4D = 0; mValidD = 0;
    mOut = 0; mDead = 0; mBuf = 0; memPend = 0; memLeft = 0; memAddr = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      mReq = !mOut && !mBuf;
      stallF = ($urandom_range(0, 3) == 0);
      stallD = ($urandom_range(0, 4) == 0);
      flushD = ($urandom_range(0, 9) == 0);
      pc_srcE = !mReq && ($urandom_range(0, 9) == 0);
      pc_targetE = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      imem_valid = memPend && (memLeft == 1);
      imem_rdata = imem_valid ? memWord(memAddr) : $urandom();
      if (mBuf) begin mWord = mBufWord; mWordAddr = mBufAddr; end
      else begin mWord = memWord(mReqAddr); mWordAddr = mReqAddr; end
      mDeliver = !pc_srcE && !stallF && !stallD && (mBuf || (mOut && !mDead && imem_valid));
      #1;
      checks++; if (imem_req !== mReq) begin errors++; $display("FAIL rnd_req[%0d] got %b want %b", cyc, imem_req, mReq); end
      checks++; if (pcF !== mPc) begin errors++; $display("FAIL rnd_pcF[%0d] got %h want %h", cyc, pcF, mPc); end
      checks++; if (fetch_busy !== !mDeliver) begin errors++; $display("FAIL rnd_busy[%0d] got %b want %b", cyc, fetch_busy, !mDeliver); end
      if (mReq) begin
        checks++; if (imem_addr !== mPc) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", cyc, imem_addr, mPc); end
      end
      @(posedge clk);
      if (memPend) begin
        if (memLeft == 1) memPend = 0;
        else memLeft--;
      end
      if (imem_req) begin memPend = 1; memLeft = $urandom_range(1, 3); memAddr = imem_addr; end
      if (flushD) begin
        mInstr = NOP; mValidD = 0;
      end else if (!stallD) begin
        if (mDeliver) begin mInstr = mWord; mPcD = mWordAddr; mPc4D = mWordAddr + 32'd4; mValidD = 1; end
        else begin mInstr = NOP; mValidD = 0; end
      end
      if (mReq) begin
        mReqAddr = mPc; mOut = 1; mDead = 0;
      end else if (mOut) begin
        if (imem_valid) begin
          mOut = 0;
          if (!mDead && !pc_srcE && (stallF || stallD)) begin mBuf = 1; mBufWord = memWord(mReqAddr); mBufAddr = mReqAddr; end
        end else if (pc_srcE) begin
          mDead = 1;
        end
      end else if (mBuf && (pc_srcE || mDeliver)) begin
        mBuf = 0;
      end
      if (pc_srcE) mPc = pc_targetE;
      else if (mDeliver) mPc = mPc + 32'd4;
      #1;
      checks++; if (instrD !== mInstr || validD !== mValidD) begin
        errors++; $display("FAIL rnd_ifid[%0d] got %h/%b want %h/%b", cyc, instrD, validD, mInstr, mValidD);
      end
      checks++; if (pcD !== mPcD || pc_plus4D !== mPc4D) begin
        errors++; $display("FAIL rnd_pcD[%0d] got %h/%h want %h/%h", cyc, pcD, pc_plus4D, mPcD, mPc4D);
      end
    end
    idleInputs();
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_basic();
    test_hold();
    test_redirect();
    test_flush_stall();
    test_wrap();
    test_reset_midwait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction word driven on a bubble (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stallF  input  1  hazard request: hold PC.
REQ-006 stallD  input  1  hazard request: hold IF/ID register.
REQ-007 flushD  input  1  hazard request: bubble IF/ID.
REQ-008 pc_srcE  input  1  branch/jump taken in Execute.
REQ-009 pc_targetE  input  32  redirect target.
REQ-010 imem_req  output  1  instruction fetch request, one cycle, always accepted.
REQ-011 imem_addr  output  32  fetch address, valid with imem_req.
REQ-012 imem_valid  input  1  response strobe, one cycle, arriving 1 or more cycles after imem_req.
REQ-013 imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-014 pcF  output  32  current fetch PC.
REQ-015 instrD, pcD, pc_plus4D  output  32 each  IF/ID register contents.
REQ-016 validD  output  1  IF/ID holds a real instruction.
REQ-017 fetch_busy  output  1  high when no instruction is being delivered this cycle, for pipeline-level stalling.

Function
REQ-018 The FSM SHALL have states ISSUE, WAIT, DROP and HOLD; at most one request is outstanding at any time.
REQ-019 ISSUE: imem_req=1, imem_addr=pcF; next state WAIT (or ISSUE if pc_srcE=1, with the request abandoned per REQ-024).
REQ-020 WAIT with imem_valid=1, pc_srcE=0 and stallF=stallD=0 (delivery): IF/ID <= {imem_rdata, pcF, pcF+4, valid=1}; pcF <= pcF+4; next state ISSUE.
REQ-021 WAIT with imem_valid=1, pc_srcE=0 and stallF or stallD=1: imem_rdata SHALL be captured in an internal buffer; next state HOLD; pcF is unchanged.
REQ-022 HOLD with stallF=stallD=0 and pc_srcE=0: IF/ID SHALL be loaded from the buffer, pcF <= pcF+4, and the next state is ISSUE.
REQ-023 pc_srcE=1 in any state: pcF <= pc_targetE, overriding stallF and any pcF+4 update.
REQ-024 When pc_srcE=1: in WAIT without imem_valid the next state is DROP; in WAIT with imem_valid, the response is discarded and the next state is ISSUE; in HOLD, the buffer is discarded and the next state is ISSUE.
REQ-025 DROP: imem_req=0; the next imem_valid response is discarded and the next state is ISSUE; pc_srcE in DROP only updates pcF.
REQ-026 IF/ID update priority: flushD=1 loads a bubble {NOP_INSTR, pcD unchanged, pc_plus4D unchanged, valid=0} even if stallD=1; otherwise stallD=1 holds the register; otherwise a delivery (REQ-020/022) loads it; otherwise a bubble is loaded.
REQ-027 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 fetch_busy SHALL be 1 in every cycle without a delivery; it is combinational.
REQ-029 Minimum throughput SHALL be one instruction per two cycles when imem_valid returns in the cycle after imem_req.

Reset
REQ-030 When rst=1 at a clock edge: pcF=RESET_PC, state=ISSUE, instrD=NOP_INSTR, pcD=0, pc_plus4D=0, validD=0, and the buffer is cleared; rst overrides all other inputs.
REQ-031 After rst deasserts, the first imem_req SHALL occur in the first cycle, with address RESET_PC.
REQ-032 A response arriving after a reset that interrupted WAIT or DROP SHALL be ignored by the post-reset request only if it arrives before that request is issued; the bench SHALL hold imem_valid low for 1 cycle after reset.

Verification
REQ-033 Reset, then 1-cycle memory returning 0x00A00093 at address 0 -> imem_req at cycle 0, validD=1, instrD=0x00A00093, pcD=0, pc_plus4D=4 after cycle 1, and the next imem_addr is 4.
REQ-034 Response arrives with stallD=stallF=1 for 3 cycles -> state HOLD, validD and IF/ID unchanged, and pcF held; release -> buffered word in instrD and pcF advances by 4.
REQ-035 pc_srcE=1 and pc_targetE=0x100 while WAIT with 3-cycle memory latency -> the late response is dropped, validD=0, and the next imem_addr is 0x100.
REQ-036 flushD=1 and stallD=1 in the same cycle -> instrD=0x00000013 and validD=0.
REQ-037 pc_srcE=1 and pc_targetE=0xFFFFFFFC, followed by a delivery -> pcD=0xFFFFFFFC, pc_plus4D=0, and the next fetch address is 0.
REQ-038 rst asserted mid-WAIT -> the next cycle has pcF=RESET_PC, validD=0 and imem_req=1.
